// File: rtl/count_6.sv
// Modulo-N up counter with enable and combinational carry-out.
// Default configuration counts 0..5 and flags the wrap on co.
module count_6 #(
    parameter int MODULUS = 6,
    parameter int WIDTH   = 4
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             co
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic at_last;
    logic in_range;

    assign at_last  = (count == LAST);
    assign in_range = (count < LAST);

    // Any value at or beyond LAST, legal or corrupt, wraps to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            if (in_range) begin
                count <= count + WIDTH'(1);
            end else begin
                count <= '0;
            end
        end
    end

    assign co = at_last && en;

endmodule

// File: tb/tb_count_6.sv
// Randomized self-checking bench for count_6 against a modulo-arithmetic model.
// The model tracks the expected count as an integer and applies (m+1) % MOD.
module tb_count_6;

    localparam int MOD = 6;
    localparam int W   = 4;

    logic         rst;
    logic         clk;
    logic         en;
    logic [W-1:0] count;
    logic         co;

    int checks;
    int failures;
    int m;

    count_6 #(.MODULUS(MOD), .WIDTH(W)) dut (
        .rst   (rst),
        .clk   (clk),
        .en    (en),
        .count (count),
        .co    (co)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Advance the model across one rising edge, then settle.
    task automatic tick();
        @(posedge clk);
        if (!rst && en) m = (m + 1) % MOD;
        #1;
    endtask

    task automatic test_reset();
        #100;
        rst = 1'b1;
        m   = 0;
        #1;
        checks++;
        if (count !== W'(0)) begin
            failures++;
            $display("FAIL reset_async count=%0d exp=0", count);
        end
        checks++;
        if (co !== 1'b0) begin
            failures++;
            $display("FAIL reset_async_co co=%0b exp=0", co);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (count !== W'(0) || co !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold count=%0d co=%0b exp=0/0", count, co);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
    endtask

    task automatic test_wrap();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (co === 1'b1) pulses++;
            checks++;
            if (count !== W'(m)) begin
                failures++;
                $display("FAIL wrap_count cyc=%0d count=%0d exp=%0d", i, count, m);
            end
            checks++;
            if (co !== (m == MOD - 1)) begin
                failures++;
                $display("FAIL wrap_co cyc=%0d co=%0b exp=%0b", i, co, (m == MOD - 1));
            end
        end
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("FAIL wrap_pulses got=%0d exp=3", pulses);
        end
    endtask

    task automatic test_hold();
        while (m != MOD - 1) tick();
        @(negedge clk);
        en = 1'b0;
        #1;
        checks++;
        if (co !== 1'b0 || count !== W'(MOD - 1)) begin
            failures++;
            $display("FAIL hold_drop count=%0d co=%0b exp=%0d/0", count, co, MOD - 1);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count !== W'(MOD - 1) || co !== 1'b0) begin
                failures++;
                $display("FAIL hold_keep count=%0d co=%0b exp=%0d/0", count, co, MOD - 1);
            end
        end
        @(negedge clk);
        en = 1'b1;
        #1;
        checks++;
        if (co !== 1'b1) begin
            failures++;
            $display("FAIL hold_reraise co=%0b exp=1", co);
        end
        tick();
        checks++;
        if (count !== W'(0) || co !== 1'b0) begin
            failures++;
            $display("FAIL hold_wrap count=%0d co=%0b exp=0/0", count, co);
        end
    endtask

    task automatic test_async_reset();
        while (m != 3) tick();
        @(negedge clk);
        #5;
        rst = 1'b1;
        m   = 0;
        #1;
        checks++;
        if (count !== W'(0)) begin
            failures++;
            $display("FAIL areset_mid count=%0d exp=0", count);
        end
        // rst spans an enabled edge, so it must win over the increment.
        tick();
        checks++;
        if (count !== W'(0) || co !== 1'b0) begin
            failures++;
            $display("FAIL areset_prio count=%0d co=%0b exp=0/0", count, co);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (count !== W'(1)) begin
            failures++;
            $display("FAIL areset_restart count=%0d exp=1", count);
        end
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            en = i[0];
            tick();
            checks++;
            if (count !== W'(m) || count >= W'(MOD)) begin
                failures++;
                $display("FAIL toggle cyc=%0d count=%0d exp=%0d", i, count, m);
            end
            checks++;
            if (co !== (m == MOD - 1 && en)) begin
                failures++;
                $display("FAIL toggle_co cyc=%0d co=%0b exp=%0b", i, co, (m == MOD - 1 && en));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            en = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                #3;
                rst = 1'b1;
                m   = 0;
                #1;
                checks++;
                if (count !== W'(0)) begin
                    failures++;
                    $display("FAIL rand_reset cyc=%0d count=%0d exp=0", i, count);
                end
                #2;
                rst = 1'b0;
            end
            tick();
            checks++;
            if (count !== W'(m)) begin
                failures++;
                $display("FAIL rand_count cyc=%0d count=%0d exp=%0d", i, count, m);
            end
            checks++;
            if (co !== (m == MOD - 1 && en)) begin
                failures++;
                $display("FAIL rand_co cyc=%0d co=%0b exp=%0b", i, co, (m == MOD - 1 && en));
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m        = 0;
        rst      = 1'b0;
        en       = 1'b0;
        test_reset();
        test_wrap();
        test_hold();
        test_async_reset();
        test_toggle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
